// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, PC step and the queue entry type for the fetch stage.
//   ADDR_W        PC / byte address width
//   INSTR_W       instruction word width
//   PC_STEP       byte distance between consecutive instructions
//   fetch_entry_t {pc, instr} pair stored in the instruction queue
package fetch_pkg;
    localparam int ADDR_W  = 32;
    localparam int INSTR_W = 32;
    localparam int PC_STEP = 4;
    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: circular FIFO of fetch entries between memory response and core.
//   clk      clock
//   reset    synchronous active-low reset
//   i_push   write i_entry at the tail
//   i_entry  entry to write
//   i_pop    drop the head entry
//   i_flush  discard everything; wins over a same-cycle push/pop
//   o_count  number of valid entries (0..DEPTH)
//   o_head   oldest entry
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  fetch_entry_t             i_entry,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [$clog2(DEPTH):0]   o_count,
    output fetch_entry_t             o_head
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t    r_mem [DEPTH];
    logic [PW-1:0]   r_rd;
    logic [PW-1:0]   r_wr;
    logic [CW-1:0]   r_count;

    always_ff @(posedge clk)
        if (i_push) r_mem[r_wr] <= i_entry;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset || i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + 1'b1;
            if (i_pop)  r_rd <= r_rd + 1'b1;
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd];
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC, credit-based fetch issue, in-flight tracking and redirect.
//   clk          clock
//   reset        synchronous active-low reset
//   pc_update    redirect pulse from core, pc_new is the target
//   imem_req     memory read enable, imem_addr the byte address
//   imem_rdata   word returned one cycle after imem_req
//   instr_valid  queue head valid; komut/instr_pc are the head word and PC
//   instr_ready  core consumes the head
//   misalign_err one-cycle pulse after a redirect with pc_new[1:0] != 0
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W      = fetch_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                QUEUE_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pc_update,
    input  logic [ADDR_W-1:0] pc_new,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       komut,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              misalign_err
);
    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_inflight_pc;
    logic              r_inflight;
    logic              r_misalign;
    logic [CW-1:0]     w_count;
    logic              w_issue;
    logic              w_pop;
    fetch_entry_t      w_entry;
    fetch_entry_t      w_head;

    // An in-flight word already owns a slot, so count it against the depth.
    assign w_issue = reset && !pc_update &&
                     (({1'b0, w_count} + {{CW{1'b0}}, r_inflight}) < (CW+1)'(QUEUE_DEPTH));
    assign w_pop   = instr_valid && instr_ready;
    assign w_entry = '{pc: r_inflight_pc, instr: imem_rdata};

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_misalign    <= 1'b0;
        end else begin
            r_misalign <= pc_update && (pc_new[1:0] != 2'b00);
            r_inflight <= w_issue;
            if (w_issue) r_inflight_pc <= r_fetch_pc;
            r_fetch_pc <= pc_update ? {pc_new[ADDR_W-1:2], 2'b00} :
                          w_issue   ? r_fetch_pc + ADDR_W'(PC_STEP) : r_fetch_pc;
        end
    end

    // A redirect flushes the queue and drops the in-flight response with it.
    fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
        .clk     (clk),
        .reset   (reset),
        .i_push  (r_inflight),
        .i_entry (w_entry),
        .i_pop   (w_pop),
        .i_flush (pc_update),
        .o_count (w_count),
        .o_head  (w_head)
    );

    assign imem_req     = w_issue;
    assign imem_addr    = r_fetch_pc;
    assign instr_valid  = (w_count != '0);
    assign komut        = w_head.instr;
    assign instr_pc     = w_head.pc;
    assign misalign_err = r_misalign;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed and random stimulus checked against a PC-stream model.
module tb_instr_fetch_unit;
    localparam int          QD       = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        reset, pc_update, instr_ready;
    logic [31:0] pc_new, imem_rdata;
    logic        imem_req, instr_valid, misalign_err;
    logic [31:0] imem_addr, komut, instr_pc;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_fetch, exp_pop, last_addr;
    logic        exp_mis;
    logic [31:0] wrap_pcs [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

    always #5 clk = ~clk;

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(RESET_PC), .QUEUE_DEPTH(QD)) dut (
        .clk          (clk),
        .reset        (reset),
        .pc_update    (pc_update),
        .pc_new       (pc_new),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .komut        (komut),
        .instr_pc     (instr_pc),
        .misalign_err (misalign_err)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Model: the core must see one unbroken +4 PC stream starting at the last
    // redirect/reset target, and fetches follow the same stream ahead of it.
    task automatic sample();
        @(negedge clk);
        last_addr = imem_addr;
        if (!reset) begin
            chk("req_in_reset", imem_req, 0);
            exp_fetch = RESET_PC;
            exp_pop   = RESET_PC;
            exp_mis   = 1'b0;
        end else begin
            chk("misalign", misalign_err, exp_mis);
            if (instr_valid && instr_ready) begin
                chk("pop_pc", instr_pc, exp_pop);
                chk("pop_word", komut, word(exp_pop));
                exp_pop += 4;
            end
            if (imem_req) begin
                chk("issue_addr", imem_addr, exp_fetch);
                exp_fetch += 4;
            end
            chk("credit", ((exp_fetch - exp_pop) >> 2) <= QD, 1);
            exp_mis = pc_update && (pc_new[1:0] != 2'b00);
            if (pc_update) begin
                chk("redir_no_issue", imem_req, 0);
                exp_fetch = pc_new & ~32'h3;
                exp_pop   = exp_fetch;
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        imem_rdata = word(last_addr);
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    initial begin
        reset = 1'b0; pc_update = 1'b0; pc_new = '0; instr_ready = 1'b0; imem_rdata = '0;
        exp_fetch = RESET_PC; exp_pop = RESET_PC; exp_mis = 1'b0; last_addr = '0;
        tick();
        sample();
        chk("rst_valid", instr_valid, 0);
        chk("rst_misalign", misalign_err, 0);
        advance();
        // streaming from reset
        reset = 1'b1; instr_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            sample();
            chk("stream_req", imem_req, 1);
            chk("stream_addr", imem_addr, 32'(4 * k));
            chk("stream_valid", instr_valid, k >= 2);
            if (k >= 2) chk("stream_pc", instr_pc, 32'(4 * (k - 2)));
            advance();
        end
        // stall with a full queue, then drain
        reset = 1'b0; instr_ready = 1'b0;
        tick();
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            sample();
            chk("stall_req", imem_req, k < 4);
            if (k < 4) chk("stall_addr", imem_addr, 32'(4 * k));
            advance();
        end
        sample();
        chk("stall_hold_addr", imem_addr, 16);
        chk("stall_req_off", imem_req, 0);
        advance();
        instr_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            sample();
            chk("drain_valid", instr_valid, 1);
            chk("drain_pc", instr_pc, 32'(4 * j));
            advance();
        end
        // mid-stream redirect
        pc_update = 1'b1; pc_new = 32'd100;
        tick();
        pc_update = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sample();
            if (k < 2) chk("redir_valid", instr_valid, 0);
            if (k == 0) chk("redir_addr", imem_addr, 100);
            if (k >= 2) chk("redir_pc", instr_pc, 32'(100 + 4 * (k - 2)));
            advance();
        end
        // redirect with a loaded queue, misaligned targets
        instr_ready = 1'b0;
        repeat (4) tick();
        pc_update = 1'b1; pc_new = 32'd50; instr_ready = 1'b1;
        tick();
        pc_update = 1'b0;
        sample();
        chk("mis1_pulse", misalign_err, 1);
        chk("mis1_addr", imem_addr, 48);
        chk("mis1_valid", instr_valid, 0);
        advance();
        pc_update = 1'b1; pc_new = 32'd25;
        sample();
        chk("mis1_end", misalign_err, 0);
        advance();
        pc_update = 1'b0;
        sample();
        chk("mis2_pulse", misalign_err, 1);
        chk("mis2_addr", imem_addr, 24);
        advance();
        sample();
        chk("mis2_end", misalign_err, 0);
        chk("mis2_valid", instr_valid, 0);
        advance();
        sample();
        chk("mis2_pc0", instr_pc, 24);
        advance();
        sample();
        chk("mis2_pc1", instr_pc, 28);
        advance();
        // back-to-back redirects: last wins
        pc_update = 1'b1; pc_new = 32'd200;
        tick();
        pc_new = 32'd300;
        tick();
        pc_update = 1'b0;
        sample();
        chk("b2b_addr", imem_addr, 300);
        chk("b2b_valid", instr_valid, 0);
        advance();
        tick();
        sample();
        chk("b2b_pc", instr_pc, 300);
        advance();
        // reset mid-operation with a simultaneous redirect
        instr_ready = 1'b0;
        repeat (4) tick();
        reset = 1'b0; pc_update = 1'b1; pc_new = 32'd500;
        tick();
        reset = 1'b1; pc_update = 1'b0;
        sample();
        chk("rst2_valid", instr_valid, 0);
        chk("rst2_addr", imem_addr, RESET_PC);
        chk("rst2_req", imem_req, 1);
        chk("rst2_misalign", misalign_err, 0);
        advance();
        repeat (2) tick();
        instr_ready = 1'b1;
        sample();
        chk("rst2_pc", instr_pc, RESET_PC);
        advance();
        // address wrap
        pc_update = 1'b1; pc_new = 32'hFFFF_FFF8;
        tick();
        pc_update = 1'b0;
        for (int k = 0; k < 6; k++) begin
            sample();
            if (k >= 2) chk("wrap_pc", instr_pc, wrap_pcs[k - 2]);
            advance();
        end
        // random traffic against the model
        for (int n = 0; n < 600; n++) begin
            reset       = ($urandom_range(0, 99) != 0);
            pc_update   = ($urandom_range(0, 15) == 0);
            pc_new      = $urandom;
            instr_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        reset = 1'b1; pc_update = 1'b0; instr_ready = 1'b1;
        repeat (8) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage directly upstream of the single-cycle datapath. Owns the program counter and drives byte addresses into the synchronous instruction memory. Buffers returned instruction words (komut) with their PCs in a small queue and hands them to the core over a valid/ready handshake. Accepts PC redirects (pc_update/pc_new) from the core and flushes stale fetches.

Parameters:
RESET_PC, 32'h0000_0000, byte address fetched first after reset
QUEUE_DEPTH, 4, instruction queue entries (power of two, 2..16)
ADDR_W, 32, PC / address width

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset; sampled on rising edge of clk
pc_update  input  1  redirect request from core, one-cycle pulse
pc_new  input  ADDR_W  redirect target byte address
imem_req  output  1  instruction memory read enable
imem_addr  output  ADDR_W  byte address to instruction memory (memory indexes addr/4)
imem_rdata  input  32  instruction word; valid exactly 1 cycle after imem_req
instr_valid  output  1  queue head holds a valid instruction
instr_ready  input  1  core accepts the head this cycle
komut  output  32  head instruction word
instr_pc  output  ADDR_W  byte address of head instruction
misalign_err  output  1  one-cycle pulse: pc_new[1:0] was nonzero

Behaviour:
- Reset (reset==0 at edge): fetch_pc<=RESET_PC; queue empty; in-flight flag cleared; misalign_err<=0. Outputs during/after reset: instr_valid=0, imem_req=0 while reset low.
- State: fetch_pc, inflight (1 bit), inflight_pc, queue (count, rd/wr pointers).
- Issue: imem_req = reset && !pc_update && (count + inflight + 0) < QUEUE_DEPTH. imem_addr = fetch_pc. On issue: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+4.
- Response: cycle after issue, if not flushed, {inflight_pc, imem_rdata} written to queue tail; inflight cleared unless a new issue occurs the same edge.
- Credit rule guarantees no overflow: an in-flight word always has a reserved slot.
- Output: instr_valid = (count!=0); komut/instr_pc driven combinationally from head. Head pops when instr_valid && instr_ready.
- Simultaneous push and pop: both performed, count unchanged; full queue + pop frees credit for issue next cycle, not the same cycle.
- Throughput: 1 instr/cycle sustained with instr_ready=1. Latency: issue at cycle N, instr_valid at cycle N+2.
- Redirect (pc_update=1): at edge, fetch_pc<=pc_new & ~3, queue cleared, inflight response discarded (not enqueued), no issue this cycle. Next cycle issues pc_new. Redirect beats a same-cycle pop, push and issue. Any handshake completing in the redirect cycle counts as consumed.
- Misalignment: pc_new[1:0]!=0 -> low bits forced to 0, misalign_err=1 for the following cycle only.
- Wrap: fetch_pc+4 is modulo 2^ADDR_W; 0xFFFF_FFFC -> 0x0000_0000, no error.
- Back-to-back redirects: the last one wins; each flushes.
- instr_ready while instr_valid=0: ignored.
- Reset mid-operation overrides everything, including a same-cycle pc_update.

Decomposition:
- fetch_pkg: ADDR_W, INSTR_W=32, PC_STEP=4, typedef fetch_entry_t {logic [ADDR_W-1:0] pc; logic [31:0] instr;}.
- Sub-module fetch_queue: circular FIFO of fetch_entry_t with push, pop, flush, count, head. Sync active-low reset. Full/empty are derived from count.
- The top level holds the PC, issue/credit logic, in-flight tracking and the redirect.

Test Plan:
1. Memory word i = 32'h1000_0000+i, RESET_PC=0, instr_ready=1, release reset -> imem_addr 0,4,8,… one per cycle. instr_valid rises 2 cycles after first issue. instr_pc 0,4,8,… with komut 0x10000000,0x10000001,…, no gaps.
2. instr_ready=0 from start -> exactly 4 issues (0..12) then imem_req=0 and fetch_pc held at 16. Raise instr_ready -> pops 0,4,8,12,16,20 in order, no loss or duplicate.
3. Mid-stream pc_update with pc_new=100 -> next cycle instr_valid=0, imem_addr=100. First popped instr_pc=100, then 104. No entry with pc<100 appears after the redirect.
4. Redirect while the queue is full and a word is in flight, then pc_new=50 -> fetch from 48, misalign_err high for one cycle. Follow with pc_new=25 -> fetch from 24, second pulse. Sequence 24,28 is delivered.
5. Drive reset=0 for one edge with 3 entries queued -> instr_valid=0 next cycle. After release, first imem_addr=RESET_PC. Also apply pc_update together with reset=0 -> redirect ignored.
6. pc_new=32'hFFFF_FFF8, instr_ready=1 -> instr_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
